// File: rtl/regfile_burst_master.sv
// Burst access controller driving the register_file write port and read port 1.
// Accepts write/read burst commands, streams write data into the register file
// and returns read data on a backpressured response stream.
module regfile_burst_master #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_last_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned CMP_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [ADDR_WIDTH-1:0] beat_cnt_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  cmd_hs;
  logic                  addr_bad;
  logic                  wdata_hs;
  logic                  rsp_capture;
  logic                  rsp_final_hs;

  // Handshake qualifiers and the register file port fan-out
  assign cmd_ready_o   = (state_q == IDLE);
  assign wdata_ready_o = (state_q == WRITE);
  assign busy_o        = (state_q != IDLE);
  assign cmd_hs        = cmd_valid_i && cmd_ready_o;
  assign wdata_hs      = wdata_valid_i && wdata_ready_o;
  assign addr_bad      = CMP_WIDTH'(cmd_addr_i) >= CMP_WIDTH'(REG_COUNT);
  assign next_addr     = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + ADDR_WIDTH'(1);

  assign rf_we_o    = rst_ni && wdata_hs;
  assign rf_waddr_o = cur_addr_q;
  assign rf_wdata_o = wdata_i;
  assign rf_raddr_o = cur_addr_q;

  // Once the last beat sits in the response register, only its handshake remains
  assign rsp_final_hs = (state_q == READ) && rsp_valid_o && rsp_last_o && rsp_ready_i;
  assign rsp_capture  = (state_q == READ) && !(rsp_valid_o && rsp_last_o) &&
                        (!rsp_valid_o || rsp_ready_i);

  // Burst sequencing, address/beat tracking and registered status outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_last_o  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_hs) begin
            if (addr_bad) begin
              err_o <= 1'b1;
            end else begin
              cur_addr_q <= cmd_addr_i;
              beat_cnt_q <= cmd_len_i;
              state_q    <= cmd_write_i ? WRITE : READ;
            end
          end
        end
        WRITE: begin
          if (wdata_hs) begin
            cur_addr_q <= next_addr;
            beat_cnt_q <= beat_cnt_q - ADDR_WIDTH'(1);
            if (beat_cnt_q == '0) begin
              state_q <= IDLE;
              done_o  <= 1'b1;
            end
          end
        end
        READ: begin
          if (rsp_final_hs) begin
            rsp_valid_o <= 1'b0;
            rsp_last_o  <= 1'b0;
            state_q     <= IDLE;
            done_o      <= 1'b1;
          end else if (rsp_capture) begin
            rsp_data_o  <= rf_rdata_i;
            rsp_valid_o <= 1'b1;
            rsp_last_o  <= (beat_cnt_q == '0);
            cur_addr_q  <= next_addr;
            beat_cnt_q  <= beat_cnt_q - ADDR_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_burst_master.sv
// Scoreboard bench for regfile_burst_master with a behavioural register file.
module tb_regfile_burst_master;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned RC = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0] rsp_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr, rf_raddr;
  logic [DW-1:0] rf_wdata, rf_rdata;
  logic          busy, done, err;

  always #5 clk = ~clk;

  regfile_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_last_o(rsp_last),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  // Behavioural register file: synchronous write, combinational read
  logic          rf_clear;
  logic [DW-1:0] rf_mem [RC];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < int'(RC); i++) rf_mem[i] <= '0;
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata = rf_mem[rf_raddr];

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { logic [DW-1:0] d; logic l; } rd_t;

  wr_t           wq[$];
  rd_t           rq[$];
  logic [DW-1:0] wd[$];
  logic [DW-1:0] exp_mem [RC];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int err_cnt = 0;
  int we_cnt = 0;
  int hs_n = 0;
  int hs_first = 0;
  int hs_last = 0;
  int rd_mode = 0;
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
    return (a == AW'(RC - 1)) ? '0 : a + AW'(1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Response readiness: always ready, or a 1,0,0 repeating pattern
  initial begin
    int tog;
    tog = 0;
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = (rd_mode == 0) ? 1'b1 : ((tog % 3) == 0);
      tog++;
    end
  end

  // Output monitor: pops the scoreboards and checks protocol properties
  always @(negedge clk) begin
    if (rst_n && !rf_clear) begin
      if (rf_we) begin
        we_cnt++;
        if (wq.size() == 0) check("wr_extra", 64'(1), 64'(0));
        else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", 64'(rf_waddr), 64'(e.a));
          check("wr_data", 64'(rf_wdata), 64'(e.d));
        end
      end
      if (rsp_valid && held_v) check("rsp_hold", 64'(rsp_data), 64'(held_d));
      if (rsp_valid && rsp_ready) begin
        held_v = 1'b0;
        if (hs_n == 0) hs_first = cyc;
        hs_last = cyc;
        hs_n++;
        if (rq.size() == 0) check("rsp_extra", 64'(1), 64'(0));
        else begin
          rd_t r;
          r = rq.pop_front();
          check("rsp_data", 64'(rsp_data), 64'(r.d));
          check("rsp_last", 64'(rsp_last), 64'(r.l));
        end
      end else if (rsp_valid) begin
        held_v = 1'b1;
        held_d = rsp_data;
      end else begin
        held_v = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check("done_cmd_ready", 64'(cmd_ready), 64'(1));
        check("done_busy", 64'(busy), 64'(0));
      end
      if (err) err_cnt++;
    end
  end

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l,
                          output logic ok);
    logic hs;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      hs = cmd_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (!ok) check("cmd_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done();
    logic fin;
    fin = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (done_cnt == exp_done && wq.size() == 0 && rq.size() == 0 && !busy) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) check("burst_timeout", 64'(0), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    check("done_cnt", 64'(done_cnt), 64'(exp_done));
  endtask

  // Write burst from wd[]; abort_at >= 0 resets the DUT before that beat
  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l,
                          input int gap_pct, input int abort_at);
    logic ok, hs;
    logic [AW-1:0] addr;
    send_cmd(1'b1, a, l, ok);
    if (!ok) return;
    addr = a;
    if (abort_at < 0) exp_done++;
    for (int i = 0; i <= int'(l); i++) begin
      if (i == abort_at) begin
        wdata_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        wdata_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      wdata_valid = 1'b1;
      wdata = wd[i];
      wq.push_back('{a: addr, d: wd[i]});
      exp_mem[addr] = wd[i];
      addr = nxt(addr);
      hs = 1'b0;
      for (int n = 0; n < 50 && !hs; n++) begin
        @(negedge clk);
        hs = wdata_ready;
        @(posedge clk);
        #1;
      end
      if (!hs) check("wdata_timeout", 64'(0), 64'(1));
    end
    wdata_valid = 1'b0;
    wait_done();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input int mode);
    logic ok;
    logic [AW-1:0] addr;
    rd_mode = mode;
    hs_n = 0;
    send_cmd(1'b0, a, l, ok);
    if (!ok) return;
    addr = a;
    for (int i = 0; i <= int'(l); i++) begin
      rq.push_back('{d: exp_mem[addr], l: (i == int'(l))});
      addr = nxt(addr);
    end
    exp_done++;
    wait_done();
    check("rsp_beats", 64'(hs_n), 64'(int'(l) + 1));
    rd_mode = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    rf_clear = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    wdata_valid = 1'b0;
    wdata = '0;
    for (int i = 0; i < int'(RC); i++) exp_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_last", 64'(rsp_last), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_we", 64'(rf_we), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rf_clear = 1'b0;
    @(posedge clk);
    #1;

    // Full-range write, data i+1
    wd.delete();
    for (int i = 0; i < 32; i++) wd.push_back(DW'(i + 1));
    we_cnt = 0;
    do_write(5'd0, 5'd31, 0, -1);
    check("write_we_cycles", 64'(we_cnt), 64'(32));

    // Full-range read at full rate
    do_read(5'd0, 5'd31, 0);
    check("read_full_rate", 64'(hs_last - hs_first), 64'(31));

    // Wrapping read and stalled reads
    do_read(5'd30, 5'd3, 0);
    do_read(5'd4, 5'd3, 1);
    do_read(5'd12, 5'd19, 1);

    // Single-beat write then read-back
    wd.delete();
    wd.push_back(32'h0000_DEAD);
    do_write(5'd5, 5'd0, 0, -1);
    do_read(5'd5, 5'd0, 0);

    // Reset on beat 3 of an 8-beat write
    wd.delete();
    for (int i = 0; i < 8; i++) wd.push_back(32'hA0 + DW'(i));
    do_write(5'd0, 5'd7, 0, 3);
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    check("abort_wq_empty", 64'(wq.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(exp_done));
    do_read(5'd0, 5'd31, 0);

    // Random wrapping write with gaps, read back under backpressure
    wd.delete();
    for (int i = 0; i < 32; i++) wd.push_back($urandom);
    do_write(5'd20, 5'd31, 30, -1);
    do_read(5'd17, 5'd31, 1);

    check("no_err", 64'(err_cnt), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
